exe_muldiv: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit inside the EXE stage. It executes
//  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and stalls the front end while it computes.
//  Its result replaces the ALU result that EXE registers into ALUout for the MEM stage.

---
 rtl/exe_muldiv.sv | 175 +++++++++++++++++
 tb/tb_exe_muldiv.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv.sv
// RV32M multiply/divide unit for EXE: iterative shift-add multiply, restoring divide.
// Define EXE_MULDIV_FAST_MUL_EN to compute MUL* in a single cycle.
module exe_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stall,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              sgn_a, sgn_b;
  logic              neg_a, neg_b, neg_res;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_div;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin;

`ifdef EXE_MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
`endif

  // Operand decode for the accept cycle
  always_comb begin
    sgn_a = funct3[2] ? ~funct3[0]
                      : (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
    sgn_b = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    neg_a = sgn_a & rs1[XLEN-1];
    neg_b = sgn_b & rs2[XLEN-1];
    mag_a = neg_a ? -rs1 : rs1;
    mag_b = neg_b ? -rs2 : rs2;
    neg_res = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
    div_zero = (rs2 == '0);
    div_ovf = funct3[2] & ~funct3[0]
            & (rs1 == {1'b1, {(XLEN-1){1'b0}}})
            & (rs2 == '1);
    if (div_zero) fast_div = funct3[1] ? rs1 : '1;
    else          fast_div = funct3[1] ? '0 : rs1;
  end

`ifdef EXE_MULDIV_FAST_MUL_EN
  always_comb begin
    fa = {{XLEN{neg_a}}, rs1};
    fb = {{XLEN{neg_b}}, rs2};
    fprod = fa * fb;
  end
`endif

  // One iteration of shift-add / restoring divide
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
            + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt = {mul_sum, acc_q[XLEN-1:1]};
    div_sh = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge = div_sh >= {1'b0, opnd_q};
    div_diff = div_sh[XLEN-1:0] - opnd_q;
    div_nxt = {div_ge ? div_diff : div_sh[XLEN-1:0],
               acc_q[XLEN-2:0], div_ge};
    step = op_q[2] ? div_nxt : mul_nxt;
    prod = neg_q ? -step : step;
    if (op_q[2]) begin
      if (op_q[1])
        fin = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
      else
        fin = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    end else begin
      fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                 : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          op_d   = funct3;
          neg_d  = neg_res;
          opnd_d = mag_b;
          acc_d  = {{XLEN{1'b0}}, mag_a};
          cnt_d  = '0;
          if (funct3[2] && (div_zero || div_ovf)) begin
            result_d = fast_div;
            state_d  = S_DONE;
`ifdef EXE_MULDIV_FAST_MUL_EN
          end else if (!funct3[2]) begin
            result_d = (funct3[1:0] == 2'b00) ? fprod[XLEN-1:0]
                                              : fprod[2*XLEN-1:XLEN];
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = fin;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign stall     = ((state_q == S_IDLE) && in_valid && !flush)
                   || (state_q == S_CALC);
  assign result    = result_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: directed RV32M cases plus random ops,
// checking result value and output cycle against a reference model.
module tb_exe_muldiv;

  localparam int XLEN = 32;
`ifdef EXE_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = XLEN;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        stall, busy, out_valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  exe_muldiv #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .stall(stall), .busy(busy), .out_valid(out_valid),
    .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] as, bs, au, bu;
    logic [63:0] p;
    int sa, sb;
    as = {{32{a[31]}}, a};
    bs = {{32{b[31]}}, b};
    au = {32'b0, a};
    bu = {32'b0, b};
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = au * bu; return p[31:0]; end
      3'd1: begin p = as * bs; return p[63:32]; end
      3'd2: begin p = as * bu; return p[63:32]; end
      3'd3: begin p = au * bu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f,
                                input logic [31:0] a,
                                input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 0;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN;
  endfunction

  // Monitor: pop and compare every out_valid pulse
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk(e.tag, result, e.res);
        chk({e.tag, "_lat"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit push,
                       input string tag);
    exp_t e;
    @(negedge clk);
    funct3 = f;
    rs1 = a;
    rs2 = b;
    in_valid = 1'b1;
    #1;
    chk({tag, "_stall_acc"}, 32'(stall), 32'd1);
    if (push) begin
      e.res = ref_op(f, a, b);
      e.due = cyc + 1 + lat_of(f, a, b);
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    funct3 = 3'($urandom);
  endtask

  task automatic drain(output int stall_cnt);
    stall_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) return;
      if (stall) stall_cnt++;
    end
    chk("drain_timeout", 32'd1, 32'd0);
    sb_q.delete();
  endtask

  task automatic run(input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input string tag);
    int sc;
    issue(f, a, b, 1'b1, tag);
    drain(sc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    logic [31:0] corner [6];
    logic [31:0] a, b;
    logic [2:0]  f;
    corner[0] = 32'h0;
    corner[1] = 32'h1;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;
    corner[5] = 32'hFFFF_FFF9;

    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    funct3 = 3'd0;
    rs1 = '0;
    rs2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, "mul");
    drain(sc);
    chk("mul_stall_cycles", 32'(sc), 32'(MUL_LAT));
    chk("mul_value", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);

    run(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh");
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");

    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
    drain(sc);
    chk("div_stall_cycles", 32'(sc), 32'(XLEN));
    run(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    run(3'd5, 32'd100, 32'd7, "divu");
    run(3'd7, 32'd100, 32'd7, "remu");

    issue(3'd4, 32'd7, 32'd0, 1'b1, "div_by0");
    drain(sc);
    chk("div_by0_stall", 32'(sc), 32'd0);
    run(3'd7, 32'd7, 32'd0, "remu_by0");
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

    // Killed divide must not produce a pulse
    issue(3'd5, 32'd100, 32'd7, 1'b0, "divu_flush");
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    run(3'd7, 32'd100, 32'd7, "remu_after_flush");

    // Asynchronous reset mid multiply
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "mulh_rst");
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_result", result, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, "mulh_after_rst");

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)]
                                       : 32'($urandom);
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)]
                                       : 32'($urandom);
      run(f, a, b, $sformatf("rnd%0d_f%0d", i, f));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
